// File: rtl/add8u_err_eval_pkg.sv
// Shared definitions for the approximate-adder error evaluator: default operand
// width, sweep FSM states and the accumulator widths derived from the operand width.
package add8u_eval_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width of one absolute error (also the worst-case error register).
    function automatic int err_w(input int w);
        return w + 1;
    endfunction

    // Sum of absolute errors over all 2^(2w) operand pairs.
    function automatic int sum_abs_w(input int w);
        return 2 * w + 9;
    endfunction

    // Number of pairs with a nonzero error, up to 2^(2w) inclusive.
    function automatic int err_cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    // Sum of squared absolute errors over all pairs.
    function automatic int sum_sq_w(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/add8u_err_eval_if.sv
// Connection bundle between the evaluator and its environment: the start request,
// the operand/result loop to the adder under test, and the status and metric outputs.
interface add8u_err_eval_if
    import add8u_eval_pkg::*;
#(
    parameter int W = W_DEF
);
    logic                      start;
    logic [W-1:0]              op_a;
    logic [W-1:0]              op_b;
    logic [W:0]                res_o;
    logic                      busy;
    logic                      done;
    logic [sum_abs_w(W)-1:0]   sum_abs_err;
    logic [err_w(W)-1:0]       wce;
    logic [err_cnt_w(W)-1:0]   err_cnt;
    logic [sum_sq_w(W)-1:0]    sum_sq_err;

    // Evaluator side.
    modport slave (
        input  start, res_o,
        output op_a, op_b, busy, done, sum_abs_err, wce, err_cnt, sum_sq_err
    );

    // Environment side: requests sweeps and closes the loop through the adder.
    modport master (
        output start, res_o,
        input  op_a, op_b, busy, done, sum_abs_err, wce, err_cnt, sum_sq_err
    );
endinterface

// File: rtl/add8u_err_eval_abs_err.sv
// Combinational exact reference sum and absolute difference against the
// approximate result; the difference is taken without wrap-around.
module add8u_abs_err #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W:0]   res_i,
    output logic [W:0]   abs_err_o
);
    logic [W:0] exact;

    assign exact     = {1'b0, a_i} + {1'b0, b_i};
    assign abs_err_o = (res_i >= exact) ? (res_i - exact) : (exact - res_i);
endmodule

// File: rtl/add8u_err_eval.sv
// Exhaustive error characterizer for an external approximate W-bit adder.
// Walks every operand pair once, registers |error| (stage 1), then folds it
// into the MAE/WCE/EP/MSE accumulators (stage 2).
module add8u_err_eval
    import add8u_eval_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter bit SQ_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    add8u_err_eval_if.slave  bus
);
    localparam int EW  = err_w(W);
    localparam int SAW = sum_abs_w(W);
    localparam int ECW = err_cnt_w(W);
    localparam int SQW = sum_sq_w(W);

    state_e             state_q, state_d;
    logic [2*W-1:0]     pair_q, pair_d;     // {op_b, op_a}
    logic               drain_q, drain_d;
    logic               clr;

    logic [EW-1:0]      abs_err;
    logic [EW-1:0]      err_q;
    logic               vld_q;

    logic [SAW-1:0]     sum_abs_q;
    logic [EW-1:0]      wce_q;
    logic [ECW-1:0]     cnt_q;
    logic [SQW-1:0]     sq_q;
    logic [SQW-1:0]     sq_term;

    add8u_abs_err #(.W(W)) u_abs_err (
        .a_i       (pair_q[W-1:0]),
        .b_i       (pair_q[2*W-1:W]),
        .res_i     (bus.res_o),
        .abs_err_o (abs_err)
    );

    // Next-state logic: accept start only in IDLE, step the pair counter, time the drain.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pair_d  = pair_q;
        drain_d = drain_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    pair_d  = '0;
                    clr     = 1'b1;
                end
            end
            SWEEP: begin
                // The last pair is sampled this cycle; hold the operands at all-ones.
                if (pair_q == '1) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    pair_d = pair_q + (2*W)'(1);
                end
            end
            DRAIN: begin
                // Two cycles: one to retire stage 1, one to retire stage 2.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and operand counter registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // pre-edge values, independent of block ordering.
        if (rst) begin
            state_q <= IDLE;
            pair_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            drain_q <= drain_d;
        end
    end

    // Stage 1: capture the error of the pair presented this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            err_q <= '0;
        end else begin
            vld_q <= (state_q == SWEEP);
            if (state_q == SWEEP) begin
                err_q <= abs_err;
            end
        end
    end

    assign sq_term = SQ_EN ? (SQW'(err_q) * SQW'(err_q)) : '0;

    // Stage 2: fold the registered error into all four metrics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_abs_q <= '0;
            wce_q     <= '0;
            cnt_q     <= '0;
            sq_q      <= '0;
        end else if (clr) begin
            sum_abs_q <= '0;
            wce_q     <= '0;
            cnt_q     <= '0;
            sq_q      <= '0;
        end else if (vld_q) begin
            sum_abs_q <= sum_abs_q + SAW'(err_q);
            sq_q      <= sq_q + sq_term;
            if (err_q > wce_q) begin
                wce_q <= err_q;
            end
            if (err_q != '0) begin
                cnt_q <= cnt_q + ECW'(1);
            end
        end
    end

    assign bus.op_a        = pair_q[W-1:0];
    assign bus.op_b        = pair_q[2*W-1:W];
    assign bus.busy        = (state_q == SWEEP) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);
    assign bus.sum_abs_err = sum_abs_q;
    assign bus.wce         = wce_q;
    assign bus.err_cnt     = cnt_q;
    assign bus.sum_sq_err  = sq_q;
endmodule

// File: tb/tb_add8u_err_eval.sv
// Directed bench: one W=8 evaluator for the full-size zero-result sweep and one
// W=4 evaluator for the remaining scenarios, each closed through a behavioural
// approximate adder. Cycle numbers count from 1 in the cycle after the edge
// that accepted start.
module tb_add8u_err_eval;
    import add8u_eval_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   mode4 = 0;   // 0 exact, 1 sum+1, 2 zero, 3 bit0 cleared
    int   mode8 = 0;   // 0 exact, 2 zero

    always #5 clk = ~clk;

    add8u_err_eval_if #(.W(8)) if8 ();
    add8u_err_eval_if #(.W(4)) if4 ();

    add8u_err_eval #(.W(8), .SQ_EN(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    add8u_err_eval #(.W(4), .SQ_EN(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    // Behavioural approximate adders.
    always_comb begin
        logic [4:0] s;
        s = {1'b0, if4.op_a} + {1'b0, if4.op_b};
        if4.res_o = s;
        case (mode4)
            1:       if4.res_o = s + 5'd1;
            2:       if4.res_o = '0;
            3:       if4.res_o = s & 5'b11110;
            default: if4.res_o = s;
        endcase
    end

    always_comb begin
        if8.res_o = {1'b0, if8.op_a} + {1'b0, if8.op_b};
        if (mode8 == 2) if8.res_o = '0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_metrics4(input string tag, input logic [63:0] sa, input logic [63:0] wc,
                                  input logic [63:0] ec, input logic [63:0] sq);
        check({tag, "_sum_abs"}, 64'(if4.sum_abs_err), sa);
        check({tag, "_wce"},     64'(if4.wce),         wc);
        check({tag, "_err_cnt"}, 64'(if4.err_cnt),     ec);
        check({tag, "_sum_sq"},  64'(if4.sum_sq_err),  sq);
    endtask

    // Start a W=4 sweep, observe a fixed 300-cycle window, optionally re-pulse
    // start during cycles pa/pb; report the first done cycle and the pulse count.
    task automatic sweep4(input int pa, input int pb, output int first_done, output int dones);
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start  = 1'b0;
        first_done = -1;
        dones      = 0;
        for (int c = 1; c <= 300; c++) begin
            if (if4.done) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
            if4.start = (c == pa) || (c == pb);
            if (c < 300) @(negedge clk);
        end
        if4.start = 1'b0;
    endtask

    initial begin
        int fd, nd, cyc, seen;

        rst       = 1'b1;
        if4.start = 1'b0;
        if8.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_w8_busy",    64'(if8.busy), 0);
        check("rst_w8_done",    64'(if8.done), 0);
        check("rst_w8_op_a",    64'(if8.op_a), 0);
        check("rst_w8_sum_abs", 64'(if8.sum_abs_err), 0);
        check("rst_w4_busy",    64'(if4.busy), 0);
        check("rst_w4_done",    64'(if4.done), 0);
        check("rst_w4_err_cnt", 64'(if4.err_cnt), 0);
        rst = 1'b0;

        // W=8, adder returns 0: full-size latency and metrics.
        mode8 = 2;
        @(negedge clk);
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        check("w8_busy_cycle1", 64'(if8.busy), 1);
        cyc = 1;
        while (!if8.done && cyc < 65600) begin
            @(negedge clk);
            cyc++;
        end
        check("w8_done_cycle", 64'(cyc),             65539);
        check("w8_busy_in_done", 64'(if8.busy),      0);
        check("w8_sum_abs",    64'(if8.sum_abs_err), 16711680);
        check("w8_wce",        64'(if8.wce),         510);
        check("w8_err_cnt",    64'(if8.err_cnt),     65535);
        check("w8_sum_sq",     64'(if8.sum_sq_err),  64'd4977295360);
        check("w8_op_a_hold",  64'(if8.op_a),        255);
        check("w8_op_b_hold",  64'(if8.op_b),        255);

        // W=4 exact adder.
        mode4 = 0;
        sweep4(0, 0, fd, nd);
        check("exact_done_cycle", 64'(fd), 259);
        check("exact_dones",      64'(nd), 1);
        check_metrics4("exact", 0, 0, 0, 0);
        check("exact_op_a_hold", 64'(if4.op_a), 15);
        check("exact_op_b_hold", 64'(if4.op_b), 15);

        // W=4 sum+1.
        mode4 = 1;
        sweep4(0, 0, fd, nd);
        check("plus1_done_cycle", 64'(fd), 259);
        check_metrics4("plus1", 256, 1, 256, 256);

        // W=4 result forced to 0.
        mode4 = 2;
        sweep4(0, 0, fd, nd);
        check_metrics4("zero", 3840, 30, 255, 68480);

        // W=4 bit0 of the result cleared: error 1 on every odd sum.
        mode4 = 3;
        sweep4(0, 0, fd, nd);
        check("bit0_done_cycle", 64'(fd), 259);
        check_metrics4("bit0", 128, 1, 128, 128);

        // Start pulses during the sweep are ignored.
        mode4 = 0;
        sweep4(10, 200, fd, nd);
        check("restart_done_cycle", 64'(fd), 259);
        check("restart_dones",      64'(nd), 1);
        check_metrics4("restart", 0, 0, 0, 0);

        // Start in the DONE cycle is ignored; in the following IDLE cycle it is accepted.
        mode4 = 1;
        sweep4(259, 260, fd, nd);
        check("donecyc_first_done", 64'(fd), 259);
        check("donecyc_dones",      64'(nd), 1);
        check("donecyc_rearmed",    64'(if4.busy), 1);
        seen = 0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (if4.done) seen = 1;
        end
        check("donecyc_second_done", 64'(seen), 1);
        check_metrics4("donecyc", 256, 1, 256, 256);

        // Reset in the middle of a sweep.
        mode4 = 1;
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_op_a",    64'(if4.op_a), 0);
        check("midrst_op_b",    64'(if4.op_b), 0);
        check("midrst_busy",    64'(if4.busy), 0);
        check("midrst_done",    64'(if4.done), 0);
        check_metrics4("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (if4.done) seen++;
        end
        check("midrst_no_done", 64'(seen), 0);
        sweep4(0, 0, fd, nd);
        check("postrst_done_cycle", 64'(fd), 259);
        check_metrics4("postrst", 256, 1, 256, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add8u_err_eval.md
ADD8U_ERR_EVAL -- requirements
Module: add8u_err_eval

Interface
REQ-001 Parameter W, default 8, operand width of the approximate adder under characterization.
REQ-002 Parameter SQ_EN, default 1, enables the sum-of-squared-error accumulator; when 0, sum_sq_err SHALL read 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-006 op_a  output  W  registered operand A driven to the external approximate adder.
REQ-007 op_b  output  W  registered operand B driven to the external approximate adder.
REQ-008 res_o  input  W+1  approximate sum returned combinationally from the adder for the current op_a/op_b.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse when all metrics are final.
REQ-011 sum_abs_err  output  2W+9  sum over all pairs of |res_o - (op_a+op_b)|; the MAE numerator.
REQ-012 wce  output  W+1  maximum absolute error seen.
REQ-013 err_cnt  output  2W+1  count of pairs with nonzero error; the EP numerator.
REQ-014 sum_sq_err  output  4W+2  sum of squared absolute errors; the MSE numerator.

Function
REQ-015 FSM states: IDLE, SWEEP, DRAIN, DONE.
REQ-016 IDLE: start=1 clears all accumulators, sets op_a=op_b=0, goes to SWEEP; start is ignored in every other state.
REQ-017 SWEEP: each cycle, sample res_o for the current pair, then advance {op_b,op_a} as one 2W-bit counter, op_a being the LSBs.
REQ-018 Pair order: (0,0),(1,0)...(2^W-1,0),(0,1)...(2^W-1,2^W-1); exactly 2^(2W) pairs, each sampled once.
REQ-019 Exact sum: zero-extended op_a + op_b, width W+1; error = |res_o - exact|, width W+1, no wrap.
REQ-020 Two-stage pipeline: stage 1 registers |error|; stage 2 updates all four accumulators.
REQ-021 After the last pair (op_a=op_b=2^W-1) is sampled, the FSM enters DRAIN; op_a/op_b hold at all-ones and do not wrap to 0.
REQ-022 DRAIN lasts exactly 2 cycles, then DONE.
REQ-023 DONE lasts 1 cycle: done=1, busy=0, then IDLE.
REQ-024 Latency: done asserts 2^(2W)+3 cycles after the edge that accepted start.
REQ-025 The metric outputs SHALL hold their final values until the next accepted start or reset.
REQ-026 Accumulator widths are sized so no overflow occurs at the worst-case error; saturation logic is not required.
REQ-027 A start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE; op_a, op_b, busy, done and all metric outputs 0; pipeline valid bits 0.
REQ-029 Reset during SWEEP or DRAIN SHALL abandon the sweep; done SHALL NOT pulse afterwards.

Structure
REQ-030 Package add8u_eval_pkg holds the W default, the FSM state enum and the derived accumulator widths.
REQ-031 Sub-module add8u_abs_err: combinational exact sum and absolute difference, parameterized by W.
REQ-032 The evaluator SHALL NOT instantiate the adder under test; it connects only through op_a, op_b and res_o.

Verification
REQ-033 Exact adder (res_o=op_a+op_b), W=8 -> done at cycle 65539; all metrics 0.
REQ-034 res_o=op_a+op_b+1 -> sum_abs_err=65536, wce=1, err_cnt=65536, sum_sq_err=65536.
REQ-035 res_o=0 -> sum_abs_err=16711680, wce=510, err_cnt=65535.
REQ-036 start pulsed again at sweep cycles 10 and 40000 -> no restart; same metrics as in REQ-033; exactly one done pulse.
REQ-037 rst asserted at sweep cycle 1000, then start -> all outputs 0 during reset; the new sweep gives the same result as a clean run.
REQ-038 W=4, res_o with bit0 forced to 0 -> wce=1 and err_cnt=128; done at cycle 259.
